// File: rtl/mem_arbiter.sv
// Two-port (CPU/host) single-RAM arbiter with round-robin ties, host lock and CPU starvation guard.
// Define MEM_ARB_HOST_PRIO_EN to make ties always go to the host instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_HOST} state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1) + 1;

  state_t              state_q, state_d;
  logic                armed_q;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cpu_rv_q, host_rv_q;
  logic [DATA_W-1:0]   cpu_rd_q, host_rd_q;
  logic                cpu_blk, cpu_force, cpu_elig, host_elig, pick_cpu;
  logic [CNT_W-1:0]    starve_inc;
`ifndef MEM_ARB_HOST_PRIO_EN
  logic                last_host_q, last_host_d;
`endif

  always_comb begin
    // The cycle being closed counts as blocked, so the CPU wins right after LOCK_MAX blocked cycles.
    cpu_blk    = cpu_req && host_lock && (state_q != ACC_CPU);
    starve_inc = starve_q + CNT_W'(cpu_blk);
    cpu_force  = (starve_inc >= CNT_W'(LOCK_MAX));
    cpu_elig   = armed_q && cpu_req && (state_q != ACC_CPU) && (!host_lock || cpu_force);
    host_elig  = armed_q && host_req && (state_q != ACC_HOST);
`ifdef MEM_ARB_HOST_PRIO_EN
    pick_cpu   = cpu_elig && (!host_elig || cpu_force);
`else
    pick_cpu   = cpu_elig && (!host_elig || cpu_force || last_host_q);
    last_host_d = last_host_q;
`endif

    state_d  = IDLE;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    if (state_q == ACC_CPU)
      starve_d = '0;
    else if (starve_inc > CNT_W'(LOCK_MAX))
      starve_d = CNT_W'(LOCK_MAX);
    else
      starve_d = starve_inc;

    if (pick_cpu) begin
      state_d = ACC_CPU;
      addr_d  = cpu_addr;
      we_d    = cpu_we;
      wdata_d = cpu_wdata;
`ifndef MEM_ARB_HOST_PRIO_EN
      last_host_d = 1'b0;
`endif
    end else if (host_elig) begin
      state_d = ACC_HOST;
      addr_d  = host_addr;
      we_d    = host_we;
      wdata_d = host_wdata;
`ifndef MEM_ARB_HOST_PRIO_EN
      last_host_d = 1'b1;
`endif
    end
  end

  // armed_q keeps the first edge after reset release free of arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      starve_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cpu_rv_q  <= 1'b0;
      host_rv_q <= 1'b0;
      cpu_rd_q  <= '0;
      host_rd_q <= '0;
`ifndef MEM_ARB_HOST_PRIO_EN
      last_host_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cpu_rv_q  <= (state_q == ACC_CPU) && !we_q;
      host_rv_q <= (state_q == ACC_HOST) && !we_q;
      if (cpu_rv_q)  cpu_rd_q  <= ram_rdata;
      if (host_rv_q) host_rd_q <= ram_rdata;
`ifndef MEM_ARB_HOST_PRIO_EN
      last_host_q <= last_host_d;
`endif
    end
  end

  // Read data passes straight through in the rvalid cycle and is held afterwards.
  assign cpu_gnt     = (state_q == ACC_CPU);
  assign host_gnt    = (state_q == ACC_HOST);
  assign cpu_rvalid  = cpu_rv_q;
  assign host_rvalid = host_rv_q;
  assign cpu_rdata   = cpu_rv_q ? ram_rdata : cpu_rd_q;
  assign host_rdata  = host_rv_q ? ram_rdata : host_rd_q;
  assign ram_addr    = addr_q;
  assign ram_we      = we_q;
  assign ram_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model behind it.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid, host_lock;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_rdata;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:255];
  int checks, failures;
  int cpu_cnt, host_cnt, cpu_at;
  logic host_at17;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; host_lock = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    pre_we = 1'b1; pre_addr = 8'h05; pre_data = 16'h1234;
    repeat (2) @(negedge clk);
    pre_we = 1'b0;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_rdata", {cpu_rdata, host_rdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Tie from IDLE: grants alternate starting with the winner of the first tie.
    cpu_req = 1; cpu_addr = 8'h01; host_req = 1; host_addr = 8'h02;
    @(negedge clk);
`ifdef MEM_ARB_HOST_PRIO_EN
    check("tie1_host_gnt", host_gnt, 1);
    check("tie1_cpu_gnt", cpu_gnt, 0);
    @(negedge clk);
    check("tie2_cpu_gnt", cpu_gnt, 1);
    check("tie2_host_gnt", host_gnt, 0);
    @(negedge clk);
    check("tie3_host_gnt", host_gnt, 1);
`else
    check("tie1_cpu_gnt", cpu_gnt, 1);
    check("tie1_host_gnt", host_gnt, 0);
    @(negedge clk);
    check("tie2_host_gnt", host_gnt, 1);
    check("tie2_cpu_gnt", cpu_gnt, 0);
    check("tie2_cpu_rvalid", cpu_rvalid, 1);
    @(negedge clk);
    check("tie3_cpu_gnt", cpu_gnt, 1);
    check("tie3_host_gnt", host_gnt, 0);
`endif
    cpu_req = 0; host_req = 0;
    @(negedge clk);
    check("tie_idle", {cpu_gnt, host_gnt}, 0);
    @(negedge clk);

    // Uncontested CPU read of preloaded word.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    @(negedge clk);
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_ram_addr", ram_addr, 8'h05);
    check("rd_ram_we", ram_we, 0);
    cpu_req = 0;
    @(negedge clk);
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 16'h1234);
    check("rd_cpu_gnt_once", cpu_gnt, 0);
    @(negedge clk);
    check("rd_rvalid_drop", cpu_rvalid, 0);
    check("rd_rdata_hold", cpu_rdata, 16'h1234);
    check("rd_addr_hold", ram_addr, 8'h05);

    // Host write then CPU read of the same address.
    host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 16'hBEEF;
    @(negedge clk);
    check("wr_host_gnt", host_gnt, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 8'h10);
    check("wr_ram_wdata", ram_wdata, 16'hBEEF);
    host_req = 0; host_we = 0;
    @(negedge clk);
    check("wr_no_rvalid", host_rvalid, 0);
    check("wr_we_idle", ram_we, 0);
    check("wr_wdata_hold", ram_wdata, 16'hBEEF);
    cpu_req = 1; cpu_addr = 8'h10;
    @(negedge clk);
    check("rb_cpu_gnt", cpu_gnt, 1);
    cpu_req = 0;
    @(negedge clk);
    check("rb_cpu_rvalid", cpu_rvalid, 1);
    check("rb_cpu_rdata", cpu_rdata, 16'hBEEF);

    // Request withdrawn before any edge sees it produces no access.
    host_req = 1; host_we = 1; host_addr = 8'h44;
    #2 host_req = 0; host_we = 0;
    @(negedge clk);
    check("drop_host_gnt", host_gnt, 0);
    check("drop_ram_we", ram_we, 0);
    @(negedge clk);

    // Host lock with both ports requesting continuously.
    host_lock = 1; host_req = 1; host_addr = 8'h20; cpu_req = 1; cpu_addr = 8'h21;
    cpu_cnt = 0; host_cnt = 0; cpu_at = 0; host_at17 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin cpu_cnt++; cpu_at = i; end
      if (host_gnt) host_cnt++;
      if (i == 17) host_at17 = host_gnt;
    end
    check("lock_cpu_gnt_count", cpu_cnt, 1);
    check("lock_cpu_gnt_cycle", cpu_at, 16);
    check("lock_host_resume", host_at17, 1);
    check("lock_host_gnt_count", host_cnt, 15);
    host_lock = 0; host_req = 0; cpu_req = 0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a CPU write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 16'hA5A5;
    @(negedge clk);
    check("ar_cpu_gnt", cpu_gnt, 1);
    check("ar_ram_we", ram_we, 1);
    #1 rst_n = 0;
    cpu_req = 0; cpu_we = 0;
    #1;
    check("ar_ram_we_async", ram_we, 0);
    check("ar_gnt_async", {cpu_gnt, host_gnt}, 0);
    check("ar_ram_addr", ram_addr, 0);
    check("ar_ram_wdata", ram_wdata, 0);
    check("ar_rdata", {cpu_rdata, host_rdata}, 0);
    @(negedge clk);
    check("ar_no_rvalid", {cpu_rvalid, host_rvalid}, 0);
    rst_n = 1; cpu_req = 1; cpu_addr = 8'h05;
    @(negedge clk);
    check("ar_first_edge_no_gnt", cpu_gnt, 0);
    @(negedge clk);
    check("ar_second_edge_gnt", cpu_gnt, 1);
    cpu_req = 0;
    @(negedge clk);
    check("ar_post_rvalid", cpu_rvalid, 1);
    check("ar_post_rdata", cpu_rdata, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- LOCK_MAX, 16, maximum consecutive cycles a pending CPU request is blocked by host_lock.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- cpu_req, in, 1, CPU access request, level, held until cpu_gnt.
- cpu_we, in, 1, CPU write (1) / read (0).
- cpu_addr, in, ADDR_W, CPU address.
- cpu_wdata, in, DATA_W, CPU write data.
- cpu_gnt, out, 1, CPU access performed this cycle.
- cpu_rvalid, out, 1, cpu_rdata valid this cycle.
- cpu_rdata, out, DATA_W, CPU read data.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same directions, widths and semantics as the CPU port.
- host_lock, in, 1, host exclusive ownership request.
- ram_addr, out, ADDR_W, RAM address.
- ram_we, out, 1, RAM write strobe.
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM read data, valid one cycle after the address edge.

Function
REQ-003 The FSM SHALL have states IDLE, ACC_CPU and ACC_HOST; exactly one port is granted per ACC cycle.
REQ-004 At each rising edge in any state, the FSM SHALL select the next owner from eligible requests: IDLE when none are eligible, ACC_CPU or ACC_HOST otherwise.
REQ-005 In ACC_x, the FSM SHALL drive ram_addr, ram_we and ram_wdata from port x's request registered at the entry edge, and SHALL assert x_gnt for exactly that cycle.
REQ-006 The port granted in the current ACC cycle SHALL be ineligible at the closing edge of that cycle, so no port is granted in two consecutive cycles.
REQ-007 On a tie, arbitration SHALL be round-robin: the port not granted most recently wins; the last-grant pointer resets to HOST, so the CPU wins the first tie.
REQ-008 While host_lock=1, the CPU SHALL be ineligible, except as required by REQ-009.
REQ-009 A starvation counter SHALL count cycles with cpu_req=1 and host_lock=1 without a CPU grant. On reaching LOCK_MAX, the CPU SHALL become eligible and win the next arbitration, and the counter SHALL clear on that cpu_gnt.
REQ-010 For a read granted in cycle N, x_rvalid SHALL be 1 in cycle N+1 with x_rdata=ram_rdata; for writes, rvalid SHALL stay 0.
REQ-011 Request-to-grant latency SHALL be 1 cycle minimum: req first high in cycle N gives gnt in N+1 when uncontested.
REQ-012 Outside ACC states, ram_we SHALL be 0 and ram_addr/ram_wdata SHALL hold their last values.
REQ-013 x_rdata SHALL hold its value when x_rvalid=0.
REQ-014 A request deasserted before its grant SHALL be dropped with no RAM access.

Reset
REQ-015 When rst_n=0, the block SHALL immediately and asynchronously force: state=IDLE, cpu_gnt=host_gnt=0, cpu_rvalid=host_rvalid=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rdata=host_rdata=0, starvation counter=0, last-grant=HOST.
REQ-016 Reset asserted during an ACC cycle SHALL abort that access; no rvalid SHALL follow, and the first grant after rst_n rises SHALL be no earlier than the second rising edge.

Configuration
REQ-017 With macro MEM_ARB_HOST_PRIO_EN defined, ties SHALL always go to the host, and the last-grant pointer SHALL be unused apart from reset.
REQ-018 Without MEM_ARB_HOST_PRIO_EN, round-robin per REQ-007 SHALL apply; REQ-006, REQ-008 and REQ-009 SHALL apply in both builds.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- CPU read addr 0x05 holding 0x1234, host idle -> cpu_gnt in cycle 1, cpu_rvalid with cpu_rdata=0x1234 in cycle 2.
- Both request from IDLE after reset (round-robin build) -> CPU granted first, host next cycle, then CPU again; grants strictly alternate.
- Host write 0xBEEF to 0x10 then CPU read of 0x10 -> cpu_rdata=0xBEEF.
- host_lock=1 with continuous host_req and cpu_req, LOCK_MAX=16 -> exactly one cpu_gnt after 16 blocked cycles, then the host resumes.
- rst_n pulled low during an ACC_CPU write -> ram_we falls asynchronously, no rvalid follows, all outputs equal their REQ-015 values.
- MEM_ARB_HOST_PRIO_EN defined, tie from IDLE -> host_gnt first.
